// File: rtl/maxpool_stream.sv
// Streaming channel-parallel 1-D pooling over KERNEL-beat windows advancing by STRIDE, restarting each frame.
// Define MAXPOOL_AVG_EN to add the mode port (0 = max, 1 = floor average); KERNEL must then be a power of two.
module maxpool_stream #(
    parameter int DATA_W    = 16,
    parameter int CHANNELS  = 4,
    parameter int KERNEL    = 2,
    parameter int STRIDE    = 2,
    parameter int FRAME_LEN = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_W*CHANNELS-1:0] in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [DATA_W*CHANNELS-1:0] out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last
`ifdef MAXPOOL_AVG_EN
    ,
    input  logic                       mode
`endif
);

    localparam int VEC_W  = DATA_W * CHANNELS;
    localparam int NWIN   = (FRAME_LEN - KERNEL) / STRIDE + 1;
    localparam int CNT_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int PH_W   = $clog2(KERNEL + 1);
    localparam int WIN_W  = (NWIN > 1) ? $clog2(NWIN) : 1;
    localparam int HIST_N = (KERNEL > 1) ? KERNEL - 1 : 1;

    if (KERNEL < 1 || KERNEL > 8) begin : g_bad_kernel
        $error("maxpool_stream: KERNEL must be in 1..8");
    end
    if (STRIDE < 1 || STRIDE > KERNEL) begin : g_bad_stride
        $error("maxpool_stream: STRIDE must be in 1..KERNEL");
    end
    if (FRAME_LEN < KERNEL) begin : g_bad_frame
        $error("maxpool_stream: FRAME_LEN must be at least KERNEL");
    end

    logic             accept;
    logic             complete;
    logic             frame_end;
    logic [CNT_W-1:0] beat_cnt;
    logic [PH_W-1:0]  phase_cnt;
    logic [WIN_W-1:0] win_left;
    logic             tail;
    logic [VEC_W-1:0] hist [HIST_N];
    logic [VEC_W-1:0] win_vec [KERNEL];
    logic [VEC_W-1:0] max_vec;
    logic [VEC_W-1:0] pool_vec;

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign frame_end = (beat_cnt == CNT_W'(FRAME_LEN - 1));
    // phase_cnt reaching zero marks a window end; tail blocks the trailing partial windows of a frame
    assign complete  = (phase_cnt == '0) && !tail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            phase_cnt <= PH_W'(KERNEL - 1);
            win_left  <= WIN_W'(NWIN - 1);
            tail      <= 1'b0;
        end else if (accept) begin
            if (frame_end) begin
                beat_cnt  <= '0;
                phase_cnt <= PH_W'(KERNEL - 1);
                win_left  <= WIN_W'(NWIN - 1);
                tail      <= 1'b0;
            end else begin
                beat_cnt  <= beat_cnt + 1'b1;
                phase_cnt <= (phase_cnt == '0) ? PH_W'(STRIDE - 1) : phase_cnt - 1'b1;
                if (complete) begin
                    if (win_left == '0) begin
                        tail <= 1'b1;
                    end else begin
                        win_left <= win_left - 1'b1;
                    end
                end
            end
        end
    end

    // hist[0] is the most recent accepted beat; stale entries across a frame wrap are never used
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HIST_N; i++) begin
                hist[i] <= '0;
            end
        end else if (accept) begin
            hist[0] <= in_data;
            for (int i = 1; i < HIST_N; i++) begin
                hist[i] <= hist[i-1];
            end
        end
    end

    always_comb begin
        win_vec[0] = in_data;
        for (int k = 1; k < KERNEL; k++) begin
            win_vec[k] = hist[k-1];
        end
    end

    logic signed [DATA_W-1:0] best;
    logic signed [DATA_W-1:0] cand;

    always_comb begin
        max_vec = '0;
        best    = '0;
        cand    = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            best = $signed(win_vec[0][c*DATA_W +: DATA_W]);
            for (int k = 1; k < KERNEL; k++) begin
                cand = $signed(win_vec[k][c*DATA_W +: DATA_W]);
                if (cand > best) begin
                    best = cand;
                end
            end
            max_vec[c*DATA_W +: DATA_W] = best;
        end
    end

`ifdef MAXPOOL_AVG_EN
    localparam int SHIFT = $clog2(KERNEL);
    localparam int ACC_W = DATA_W + SHIFT;

    if ((1 << SHIFT) != KERNEL) begin : g_bad_avg_kernel
        $error("maxpool_stream: average mode needs a power-of-two KERNEL");
    end

    logic signed [ACC_W-1:0] acc;
    logic [VEC_W-1:0]        avg_vec;

    // Sum is wide enough for KERNEL samples; the arithmetic shift floors toward minus infinity
    always_comb begin
        avg_vec = '0;
        acc     = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            acc = '0;
            for (int k = 0; k < KERNEL; k++) begin
                acc = acc + ACC_W'($signed(win_vec[k][c*DATA_W +: DATA_W]));
            end
            avg_vec[c*DATA_W +: DATA_W] = DATA_W'(acc >>> SHIFT);
        end
    end

    assign pool_vec = mode ? avg_vec : max_vec;
`else
    assign pool_vec = max_vec;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (accept && complete) begin
            out_valid <= 1'b1;
            out_last  <= (win_left == '0);
            out_data  <= pool_vec;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_maxpool_stream.sv
// Self-checking bench for maxpool_stream: three configurations against a per-frame window model.
// Directed cases from the block's documented examples, then randomized traffic with back-pressure and a reset.
`timescale 1ns/1ps
module tb_maxpool_stream;

    localparam int DW = 16;
    localparam int CH = 4;
    localparam int VW = DW * CH;
    localparam int ND = 3;
`ifdef MAXPOOL_AVG_EN
    localparam int OVL_K = 4;
    localparam int OVL_F = 6;
`else
    localparam int OVL_K = 3;
    localparam int OVL_F = 5;
`endif
    localparam int K_P [ND] = '{2, OVL_K, 2};
    localparam int S_P [ND] = '{2, 1, 2};
    localparam int F_P [ND] = '{16, OVL_F, 5};

    typedef logic [VW-1:0] vec_t;
    typedef struct {
        int   dut;
        vec_t data;
        logic last;
    } log_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    vec_t in_data_d  [ND];
    vec_t out_data_d [ND];
    logic in_valid_d [ND];
    logic in_ready_d [ND];
    logic out_valid_d[ND];
    logic out_ready_d[ND];
    logic out_last_d [ND];
`ifdef MAXPOOL_AVG_EN
    logic mode_d     [ND];
`endif

    always #5 clk = ~clk;

    maxpool_stream #(.DATA_W(DW), .CHANNELS(CH), .KERNEL(2), .STRIDE(2), .FRAME_LEN(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data_d[0]), .in_valid(in_valid_d[0]), .in_ready(in_ready_d[0]),
        .out_data(out_data_d[0]), .out_valid(out_valid_d[0]), .out_ready(out_ready_d[0]),
        .out_last(out_last_d[0])
`ifdef MAXPOOL_AVG_EN
        , .mode(mode_d[0])
`endif
    );

    maxpool_stream #(.DATA_W(DW), .CHANNELS(CH), .KERNEL(OVL_K), .STRIDE(1), .FRAME_LEN(OVL_F)) u_ovl (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data_d[1]), .in_valid(in_valid_d[1]), .in_ready(in_ready_d[1]),
        .out_data(out_data_d[1]), .out_valid(out_valid_d[1]), .out_ready(out_ready_d[1]),
        .out_last(out_last_d[1])
`ifdef MAXPOOL_AVG_EN
        , .mode(mode_d[1])
`endif
    );

    maxpool_stream #(.DATA_W(DW), .CHANNELS(CH), .KERNEL(2), .STRIDE(2), .FRAME_LEN(5)) u_frm (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data_d[2]), .in_valid(in_valid_d[2]), .in_ready(in_ready_d[2]),
        .out_data(out_data_d[2]), .out_valid(out_valid_d[2]), .out_ready(out_ready_d[2]),
        .out_last(out_last_d[2])
`ifdef MAXPOOL_AVG_EN
        , .mode(mode_d[2])
`endif
    );

    int   checks;
    int   failures;
    bit   log_en;
    log_t log_q[$];
    vec_t frame_buf[ND][16];
    int   frame_cnt[ND];
    bit   pend[ND];
    vec_t exp_data[ND];
    bit   exp_last[ND];
    bit   rdy_m;

    task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic vec_t pack_fn(input int base, input int inc);
        vec_t v;
        for (int c = 0; c < CH; c++) v[c*DW +: DW] = DW'(base + inc * c);
        return v;
    endfunction

    function automatic int sval(input vec_t v, input int c);
        logic signed [DW-1:0] s;
        s = v[c*DW +: DW];
        return int'(s);
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        int   r;
        for (int c = 0; c < CH; c++) begin
            r = $urandom();
            case ($urandom_range(0, 5))
                0:       v[c*DW +: DW] = 16'h8000;
                1:       v[c*DW +: DW] = 16'h7fff;
                2:       v[c*DW +: DW] = 16'hffff;
                3:       v[c*DW +: DW] = DW'($urandom_range(0, 7));
                default: v[c*DW +: DW] = DW'(r);
            endcase
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ND; i++) begin
            pend[i] = 1'b0;
            frame_cnt[i] = 0;
        end
    endtask

    // Store the beat at its frame position; if it closes a full window, predict that window's result
    task automatic model_beat(input int i, input vec_t d, input bit avg);
        int b, k, s, nw, w, v, sum, mx, res;
        k  = K_P[i];
        s  = S_P[i];
        nw = (F_P[i] - k) / s + 1;
        b  = frame_cnt[i];
        frame_buf[i][b] = d;
        if (b >= k - 1 && (b - k + 1) % s == 0 && (b - k + 1) / s < nw) begin
            w = (b - k + 1) / s;
            pend[i] = 1'b1;
            exp_last[i] = (w == nw - 1);
            for (int c = 0; c < CH; c++) begin
                sum = 0;
                mx  = -(1 << 30);
                for (int j = b - k + 1; j <= b; j++) begin
                    v = sval(frame_buf[i][j], c);
                    sum += v;
                    if (v > mx) mx = v;
                end
                res = avg ? (sum - (((sum % k) + k) % k)) / k : mx;
                exp_data[i][c*DW +: DW] = DW'(res);
            end
        end
        frame_cnt[i] = (b + 1 == F_P[i]) ? 0 : b + 1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < ND; i++) begin
                rdy_m = !pend[i] || out_ready_d[i];
                chk($sformatf("in_ready[%0d]", i), in_ready_d[i], rdy_m);
                chk($sformatf("out_valid[%0d]", i), out_valid_d[i], pend[i]);
                if (pend[i] && out_ready_d[i]) begin
                    chk($sformatf("out_data[%0d]", i), out_data_d[i], exp_data[i]);
                    chk($sformatf("out_last[%0d]", i), out_last_d[i], exp_last[i]);
                    if (log_en) log_q.push_back('{i, out_data_d[i], out_last_d[i]});
                    pend[i] = 1'b0;
                end
                if (in_valid_d[i] && rdy_m) begin
`ifdef MAXPOOL_AVG_EN
                    model_beat(i, in_data_d[i], mode_d[i]);
`else
                    model_beat(i, in_data_d[i], 1'b0);
`endif
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int i, input vec_t v);
        in_valid_d[i] = 1'b1;
        in_data_d[i]  = v;
        step();
        in_valid_d[i] = 1'b0;
    endtask

    task automatic check_log(input string tag, input int idx, input vec_t d, input logic last);
        if (idx < log_q.size()) begin
            chk({tag, "_data"}, log_q[idx].data, d);
            chk({tag, "_last"}, log_q[idx].last, last);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("rst_valid[%0d]", i), out_valid_d[i], 1'b0);
            chk($sformatf("rst_in_ready[%0d]", i), in_ready_d[i], 1'b1);
        end
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        log_en = 1'b0;
        for (int i = 0; i < ND; i++) begin
            in_valid_d[i]  = 1'b0;
            in_data_d[i]   = '0;
            out_ready_d[i] = 1'b1;
`ifdef MAXPOOL_AVG_EN
            mode_d[i] = 1'b0;
`endif
        end
        model_reset();
        #12;
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("reset_valid[%0d]", i), out_valid_d[i], 1'b0);
            chk($sformatf("reset_last[%0d]", i), out_last_d[i], 1'b0);
            chk($sformatf("reset_data[%0d]", i), out_data_d[i], '0);
            chk($sformatf("reset_in_ready[%0d]", i), in_ready_d[i], 1'b1);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // full default frame: window w carries beat 2w+1
        log_en = 1'b1;
        log_q.delete();
        for (int b = 0; b < 16; b++) feed(0, pack_fn(b * 4, 1));
        step();
        step();
        chk("t1_count", log_q.size(), 8);
        for (int w = 0; w < 8; w++) check_log("t1", w, pack_fn((2 * w + 1) * 4, 1), w == 7);

        log_q.delete();
        feed(0, pack_fn(-5, 0));
        feed(0, pack_fn(-32768, 0));
        feed(0, pack_fn(100, 0));
        feed(0, pack_fn(-1, 0));
        step();
        step();
        chk("signed_count", log_q.size(), 2);
        check_log("signed0", 0, pack_fn(-5, 0), 1'b0);
        check_log("signed1", 1, pack_fn(100, 0), 1'b0);

`ifndef MAXPOOL_AVG_EN
        log_q.delete();
        feed(1, pack_fn(1, 0));
        feed(1, pack_fn(7, 0));
        feed(1, pack_fn(2, 0));
        feed(1, pack_fn(9, 0));
        feed(1, pack_fn(3, 0));
        step();
        step();
        chk("ovl_count", log_q.size(), 3);
        check_log("ovl0", 0, pack_fn(7, 0), 1'b0);
        check_log("ovl1", 1, pack_fn(9, 0), 1'b0);
        check_log("ovl2", 2, pack_fn(9, 0), 1'b1);
`endif

        // stall with a pending result, a new beat offered throughout
        log_q.delete();
        out_ready_d[0] = 1'b0;
        feed(0, pack_fn(50, -1));
        feed(0, pack_fn(40, 1));
        in_valid_d[0] = 1'b1;
        in_data_d[0]  = pack_fn(200, 3);
        for (int n = 0; n < 5; n++) begin
            chk("bp_in_ready", in_ready_d[0], 1'b0);
            chk("bp_valid", out_valid_d[0], 1'b1);
            chk("bp_data", out_data_d[0], pack_fn(50, -1));
            chk("bp_last", out_last_d[0], 1'b0);
            step();
        end
        out_ready_d[0] = 1'b1;
        step();
        for (int b = 7; b < 16; b++) feed(0, pack_fn(b * 10, -2));
        step();
        step();
        chk("bp_count", log_q.size(), 6);
        check_log("bp_w2", 0, pack_fn(50, -1), 1'b0);
        check_log("bp_w3", 1, pack_fn(200, 3), 1'b0);
        for (int w = 4; w < 8; w++) check_log("bp_wn", w - 2, pack_fn((2 * w + 1) * 10, -2), w == 7);

        log_q.delete();
        for (int b = 1; b <= 4; b++) feed(2, pack_fn(b, 0));
        feed(2, pack_fn(99, 0));
        for (int b = 5; b <= 9; b++) feed(2, pack_fn(b, 0));
        step();
        step();
        chk("frm_count", log_q.size(), 4);
        check_log("frm0", 0, pack_fn(2, 0), 1'b0);
        check_log("frm1", 1, pack_fn(4, 0), 1'b1);
        check_log("frm2", 2, pack_fn(6, 0), 1'b0);
        check_log("frm3", 3, pack_fn(8, 0), 1'b1);

        // reset with a partial window in u_frm and a pending output in u_dut
        feed(2, pack_fn(500, 0));
        out_ready_d[0] = 1'b0;
        feed(0, pack_fn(1, 0));
        feed(0, pack_fn(2, 0));
        chk("pre_rst_valid", out_valid_d[0], 1'b1);
        do_reset();
        out_ready_d[0] = 1'b1;
        log_q.delete();
        for (int b = 1; b <= 5; b++) feed(2, pack_fn(b * 10, 0));
        step();
        step();
        chk("rst_frm_count", log_q.size(), 2);
        check_log("rst_frm0", 0, pack_fn(20, 0), 1'b0);
        check_log("rst_frm1", 1, pack_fn(40, 0), 1'b1);

`ifdef MAXPOOL_AVG_EN
        log_q.delete();
        mode_d[0] = 1'b1;
        feed(0, pack_fn(3, 0));
        feed(0, pack_fn(4, 0));
        feed(0, pack_fn(-3, 0));
        feed(0, pack_fn(-4, 0));
        mode_d[0] = 1'b0;
        feed(0, pack_fn(3, 0));
        feed(0, pack_fn(4, 0));
        feed(0, pack_fn(-3, 0));
        feed(0, pack_fn(-4, 0));
        step();
        step();
        chk("avg_count", log_q.size(), 4);
        check_log("avg0", 0, pack_fn(3, 0), 1'b0);
        check_log("avg1", 1, pack_fn(-4, 0), 1'b0);
        check_log("avg2", 2, pack_fn(4, 0), 1'b0);
        check_log("avg3", 3, pack_fn(-3, 0), 1'b0);
`endif

        log_en = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < ND; i++) begin
                in_valid_d[i]  = ($urandom_range(0, 3) != 0);
                in_data_d[i]   = rand_vec();
                out_ready_d[i] = ($urandom_range(0, 3) != 0);
`ifdef MAXPOOL_AVG_EN
                mode_d[i] = ($urandom_range(0, 1) != 0);
`endif
            end
            if (n == 1500) do_reset();
            step();
        end

        for (int i = 0; i < ND; i++) begin
            in_valid_d[i]  = 1'b0;
            out_ready_d[i] = 1'b1;
        end
        step();
        step();
        step();
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("end_pending[%0d]", i), pend[i], 1'b0);
            chk($sformatf("end_valid[%0d]", i), out_valid_d[i], 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/maxpool_stream.md
# maxpool_stream

Streaming, channel-parallel 1-D pooling stage for the keyword-spotting feature pipeline. Sits between a convolution stage and the next layer. It accepts one time step per handshake beat: CHANNELS signed samples in parallel. It emits one pooled vector per completed window of KERNEL beats, advancing by STRIDE beats and restarting at every frame boundary. It supersedes the fixed-shape pooling block and adds:

- arbitrary kernel/stride, including overlapping windows
- signed data
- valid/ready back-pressure
- a frame-last marker

## Interface
Parameters:
- DATA_W, 16, bits per signed sample
- CHANNELS, 4, channels per beat, processed in parallel
- KERNEL, 2, window length in beats (1..8)
- STRIDE, 2, window advance in beats (1..KERNEL)
- FRAME_LEN, 16, beats per frame (≥ KERNEL)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_data  in  DATA_W*CHANNELS  channel c at bits [c*DATA_W +: DATA_W], two's complement
- in_valid  in  1  input beat offered
- in_ready  out  1  input beat can be accepted
- out_data  out  DATA_W*CHANNELS  pooled vector, same packing as in_data
- out_valid  out  1  out_data holds a result
- out_ready  in  1  downstream accepts
- out_last  out  1  result is the final window of its frame
- mode  in  1  only present with MAXPOOL_AVG_EN: 0 = max, 1 = average

## Operation
- A beat is accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready (combinational). A new result can overwrite the output register in the same cycle the old one is taken.
- Beat index b counts accepted beats 0..FRAME_LEN-1 and wraps to 0 after FRAME_LEN-1. The next beat starts a new frame.
- A history register holds the previous KERNEL-1 accepted beats of the current frame. Beats from a prior frame never join a window.
- Window w covers beats w*STRIDE .. w*STRIDE+KERNEL-1, for w = 0..NWIN-1, where NWIN = (FRAME_LEN-KERNEL)/STRIDE + 1 (integer division).
- A window completes on the accepted beat b = w*STRIDE+KERNEL-1. The result is computed from the history plus that beat and registered to out_data.
- Trailing beats after the last full window are consumed and discarded; partial windows are never emitted.
- Max mode: per-channel signed maximum over the KERNEL samples. Ties are irrelevant because values are equal. Example: -5 > -32768.
- out_last = 1 exactly on window NWIN-1.
- KERNEL=1, STRIDE=1 is pass-through with one cycle of latency.

## Timing
- Reset values:
  - out_valid=0, out_last=0, out_data=0
  - beat counter = 0, history = 0
  - in_ready=1 (follows from out_valid=0)
- Latency: out_valid rises on the clock edge that accepts the completing beat; data is visible the following cycle.
- Throughput: one beat per cycle while out_ready=1.
- Handshake:
  - out_data and out_last hold stable while out_valid && !out_ready.
  - out_valid clears on out_ready unless a new completing beat is accepted in the same cycle.
- Back-pressure: with out_valid=1 and out_ready=0, in_ready=0. No beat is accepted and no state advances.
- Non-completing beats are accepted whenever in_ready=1; they do not disturb a pending output.
- Frame wrap: on the accepted beat at b=FRAME_LEN-1, the counter returns to 0 and the history is logically invalidated. The window logic uses b, not the stored contents.
- Asynchronous reset mid-frame:
  - The partial window and any pending output are discarded.
  - The next accepted beat is b=0.

## Configuration
- MAXPOOL_AVG_EN defined:
  - The mode port exists; mode is sampled on the completing beat.
  - mode=1 produces per-channel average = (signed sum over KERNEL samples) >>> log2(KERNEL). This is an arithmetic shift, rounding toward −∞.
  - The accumulator is DATA_W+$clog2(KERNEL) bits and cannot overflow.
  - KERNEL must be a power of two; elaboration fails otherwise.
- MAXPOOL_AVG_EN undefined: no mode port, no adder logic, max pooling only.

## Test plan
- Reset, then defaults: feed 16 beats with channel c = b*4+c → 8 results, window w channel c = (2w+1)*4+c; out_last only on w=7; one-cycle latency.
- Signed data: KERNEL=2, beats ch0 = -5 then -32768 → out ch0 = -5; beats 100 then -1 → 100.
- Overlap: KERNEL=3, STRIDE=1, FRAME_LEN=5, ch0 = 1,7,2,9,3 → outputs 7,9,9; out_last on the third.
- Back-pressure: hold out_ready=0 for 5 cycles with a result pending → in_ready=0, out_data and out_last stable, no beats lost; release → stream resumes correctly.
- Frame boundary and reset: FRAME_LEN=5, KERNEL=2, STRIDE=2 → 2 results per frame, beat 4 discarded, frame 2 independent of frame 1. Assert rst_n mid-window → out_valid=0 immediately, and the next frame's results are correct.
- MAXPOOL_AVG_EN, mode=1, KERNEL=2: samples 3,4 → 3; samples -3,-4 → -4; mode=0 on the same data → 4 and -3.
